// File: rtl/pwm_fade_sequencer_pkg.sv
// Shared types and default constants for the LED breathing-fade sequencer.
package pwm_fade_sequencer_pkg;

    // Sequencer states; the encoding is visible on phase_out and must not change.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } fade_state_e;

    localparam int DEFAULT_COUNTER_WIDTH = 32'd3;
    localparam int DEFAULT_MAX_COUNT     = 32'd7;
    localparam int DEFAULT_STEP_WIDTH    = 32'd8;

endpackage : pwm_fade_sequencer_pkg

// File: rtl/pwm_fade_sequencer_pwm_core.sv
// Free-running PWM counter with synchronous clear and a registered comparator.
// period_end marks the last clock of each PWM period so duty can change cleanly.
module pwm_fade_sequencer_pwm_core
    import pwm_fade_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int MAX_COUNT     = DEFAULT_MAX_COUNT
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     clr,
    input  logic [COUNTER_WIDTH-1:0] duty,
    output logic                     period_end,
    output logic                     pwm
);

    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX  = COUNTER_WIDTH'(MAX_COUNT);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] count_r;
    logic                     pwm_r;

    assign period_end = (count_r == COUNT_MAX);
    assign pwm        = pwm_r;

    // Period counter: wraps at COUNT_MAX, restarts on a synchronous clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_r <= COUNT_ZERO;
        end else if (clr) begin
            count_r <= COUNT_ZERO;
        end else if (count_r == COUNT_MAX) begin
            count_r <= COUNT_ZERO;
        end else begin
            count_r <= count_r + COUNT_ONE;
        end
    end

    // Registered comparator so the LED drive is glitch-free.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= (count_r < duty);
        end
    end

endmodule : pwm_fade_sequencer_pwm_core

// File: rtl/pwm_fade_sequencer.sv
// Breathing-fade controller: ramps PWM duty up, holds at maximum, ramps down.
// Duty only changes on PWM period boundaries; enable_in low aborts a run.
module pwm_fade_sequencer
    import pwm_fade_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
    parameter int MAX_COUNT     = DEFAULT_MAX_COUNT,
    parameter int STEP_WIDTH    = DEFAULT_STEP_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     enable_in,
    input  logic                     start_in,
    input  logic                     repeat_in,
    input  logic [STEP_WIDTH-1:0]    step_div_in,
    input  logic [STEP_WIDTH-1:0]    hold_in,
    output logic                     busy_out,
    output logic [1:0]               phase_out,
    output logic [COUNTER_WIDTH-1:0] duty_out,
    output logic                     pwm_out,
    output logic                     done_out
);

    localparam logic [COUNTER_WIDTH-1:0] DUTY_MAX  = COUNTER_WIDTH'(MAX_COUNT);
    localparam logic [COUNTER_WIDTH-1:0] DUTY_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] DUTY_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STEP_WIDTH-1:0]    STEP_ZERO = {STEP_WIDTH{1'b0}};
    localparam logic [STEP_WIDTH-1:0]    STEP_ONE  = {{(STEP_WIDTH-1){1'b0}}, 1'b1};

    fade_state_e              state_r;
    fade_state_e              state_nxt_s;
    logic [COUNTER_WIDTH-1:0] duty_r;
    logic [COUNTER_WIDTH-1:0] duty_nxt_s;
    logic [STEP_WIDTH-1:0]    step_cnt_r;
    logic [STEP_WIDTH-1:0]    step_cnt_nxt_s;
    logic [STEP_WIDTH-1:0]    hold_cnt_r;
    logic [STEP_WIDTH-1:0]    hold_cnt_nxt_s;
    logic [STEP_WIDTH-1:0]    step_div_r;
    logic [STEP_WIDTH-1:0]    hold_r;
    logic                     done_r;
    logic                     done_nxt_s;
    logic                     capture_s;
    logic                     pwm_clr_s;
    logic                     period_end_s;
    logic                     pwm_s;
    logic                     busy_s;
    logic [1:0]               phase_s;

    logic [STEP_WIDTH-1:0]    step_div_eff_s;
    logic [STEP_WIDTH-1:0]    step_inc_s;
    logic [STEP_WIDTH-1:0]    hold_inc_s;
    logic                     step_hit_s;
    logic [COUNTER_WIDTH-1:0] duty_up_s;
    logic [COUNTER_WIDTH-1:0] duty_dn_s;

    // A divider of zero behaves as one step per period.
    assign step_div_eff_s = (step_div_r == STEP_ZERO) ? STEP_ONE : step_div_r;
    assign step_inc_s     = step_cnt_r + STEP_ONE;
    assign hold_inc_s     = hold_cnt_r + STEP_ONE;
    assign step_hit_s     = (step_inc_s == step_div_eff_s);
    assign duty_up_s      = duty_r + DUTY_ONE;
    assign duty_dn_s      = duty_r - DUTY_ONE;

    pwm_fade_sequencer_pwm_core #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .MAX_COUNT     (MAX_COUNT)
    ) u_pwm_core (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .clr        (pwm_clr_s),
        .duty       (duty_r),
        .period_end (period_end_s),
        .pwm        (pwm_s)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath-update decisions; enable low overrides everything.
    always_comb begin
        state_nxt_s    = state_r;
        duty_nxt_s     = duty_r;
        step_cnt_nxt_s = step_cnt_r;
        hold_cnt_nxt_s = hold_cnt_r;
        done_nxt_s     = 1'b0;
        capture_s      = 1'b0;
        pwm_clr_s      = 1'b0;
        if (!enable_in) begin
            state_nxt_s    = ST_IDLE;
            duty_nxt_s     = DUTY_ZERO;
            step_cnt_nxt_s = STEP_ZERO;
            hold_cnt_nxt_s = STEP_ZERO;
            pwm_clr_s      = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        capture_s      = 1'b1;
                        pwm_clr_s      = 1'b1;
                        step_cnt_nxt_s = STEP_ZERO;
                        hold_cnt_nxt_s = STEP_ZERO;
                        state_nxt_s    = ST_RAMP_UP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RAMP_UP: begin
                    if (period_end_s && step_hit_s) begin
                        step_cnt_nxt_s = STEP_ZERO;
                        duty_nxt_s     = duty_up_s;
                        if (duty_up_s == DUTY_MAX) begin
                            if (hold_r == STEP_ZERO) begin
                                state_nxt_s = ST_RAMP_DOWN;
                            end else begin
                                hold_cnt_nxt_s = STEP_ZERO;
                                state_nxt_s    = ST_HOLD;
                            end
                        end else begin
                            state_nxt_s = ST_RAMP_UP;
                        end
                    end else if (period_end_s) begin
                        step_cnt_nxt_s = step_inc_s;
                    end else begin
                        state_nxt_s = ST_RAMP_UP;
                    end
                end
                ST_HOLD: begin
                    if (period_end_s && (hold_inc_s == hold_r)) begin
                        step_cnt_nxt_s = STEP_ZERO;
                        state_nxt_s    = ST_RAMP_DOWN;
                    end else if (period_end_s) begin
                        hold_cnt_nxt_s = hold_inc_s;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (period_end_s && step_hit_s) begin
                        step_cnt_nxt_s = STEP_ZERO;
                        duty_nxt_s     = duty_dn_s;
                        if (duty_dn_s == DUTY_ZERO) begin
                            done_nxt_s = 1'b1;
                            if (repeat_in) begin
                                capture_s   = 1'b1;
                                state_nxt_s = ST_RAMP_UP;
                            end else begin
                                state_nxt_s = ST_IDLE;
                            end
                        end else begin
                            state_nxt_s = ST_RAMP_DOWN;
                        end
                    end else if (period_end_s) begin
                        step_cnt_nxt_s = step_inc_s;
                    end else begin
                        state_nxt_s = ST_RAMP_DOWN;
                    end
                end
                default: begin
                    state_nxt_s    = ST_IDLE;
                    duty_nxt_s     = DUTY_ZERO;
                    step_cnt_nxt_s = STEP_ZERO;
                    hold_cnt_nxt_s = STEP_ZERO;
                    pwm_clr_s      = 1'b1;
                end
            endcase
        end
    end

    // Duty, step/hold counters and the end-of-run pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            duty_r     <= DUTY_ZERO;
            step_cnt_r <= STEP_ZERO;
            hold_cnt_r <= STEP_ZERO;
            done_r     <= 1'b0;
        end else begin
            duty_r     <= duty_nxt_s;
            step_cnt_r <= step_cnt_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    // Configuration snapshot taken at the start of every run.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            step_div_r <= STEP_ZERO;
            hold_r     <= STEP_ZERO;
        end else if (capture_s) begin
            step_div_r <= step_div_in;
            hold_r     <= hold_in;
        end else begin
            step_div_r <= step_div_r;
            hold_r     <= hold_r;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy_s  = (state_r != ST_IDLE);
        phase_s = state_r;
    end

    assign busy_out  = busy_s;
    assign phase_out = phase_s;
    assign duty_out  = duty_r;
    assign pwm_out   = pwm_s;
    assign done_out  = done_r;

endmodule : pwm_fade_sequencer
